rng_stream_ctrl: RTL and testbench
==================================

# rng_stream_ctrl

Command-driven scheduler between the UART and the free-running randomized LFSR source. It decodes command bytes received by the UART and decides when the TX path carries random bytes, whether as a continuous stream or a counted burst. It injects status replies with priority over random data and paces all transmit requests against the UART's `tx_free` handshake. It sits in the top level in place of the direct `tx_free`→`transmit` loopback.

## Interface
- `COUNT_W`, default 16: burst counter width; burst length range 0..2^COUNT_W-1.
- `ARG_TIMEOUT`, default 120000: clk cycles allowed between bytes of a multi-byte command (10 ms at 12 MHz).

Ports:
- `clk`, in, 1: system clock; one clock domain only.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `rx_valid`, in, 1: one-cycle pulse; `rx_byte` is valid in that cycle (UART `received`).
- `rx_byte`, in, 8: received byte.
- `rnd_byte`, in, 8: current random byte (`lfsr[7:0]`), sampled when a random byte is issued.
- `tx_free`, in, 1: UART transmitter idle.
- `tx_start`, out, 1: registered one-cycle transmit request (UART `transmit`).
- `tx_byte`, out, 8: registered byte; held stable from the `tx_start` cycle until the next `tx_start`.
- `stream_active`, out, 1: continuous mode on.
- `burst_active`, out, 1: burst counter nonzero.
- `cmd_error`, out, 1: one-cycle pulse on argument timeout.

## Operation
- Commands (on `rx_valid`, parser in P_IDLE):
  - 0x73 's': `stream_active`←1, burst counter←0.
  - 0x70 'p': `stream_active`←0, burst counter←0. A pending status reply is kept.
  - 0x3F '?': status_pending←1. A repeat while pending is absorbed and produces one reply.
  - 0x62 'b': go to P_HI. The next byte is count[15:8], then go to P_LO. The next byte is count[7:0], then go to P_IDLE, load the counter, and set `stream_active`←0. A count of 0 loads 0, so nothing is sent.
  - All other bytes, including 0x72, are ignored with no state change.
- In P_HI/P_LO, every byte is treated as an argument, including command codes.
- Timeout counter:
  - Reloads on entry to P_HI and on each argument byte.
  - If it expires before the next byte, return to P_IDLE, pulse `cmd_error`, and set err_sticky.
  - No counter load happens in that case.
- For COUNT_W<16, the argument is truncated to its low COUNT_W bits.
- Status byte: {4'hA, err_sticky, parser≠P_IDLE, `burst_active`, `stream_active`}.
  - The snapshot is taken at the issuing edge.
  - err_sticky clears on that same edge.
- TX scheduler FSM:
  - T_IDLE: if `tx_free`=1, pick a source by priority and issue. Go to T_HOLD.
    - Priority 1: status_pending; clear it.
    - Priority 2: `stream_active` or `burst_active` → random byte (`rnd_byte`); decrement the counter if `burst_active`.
    - Otherwise stay in T_IDLE.
  - T_HOLD: `tx_free` is ignored for exactly one cycle, then return to T_IDLE.
- A status reply issued during a burst does not decrement the counter.
- Simultaneous events:
  - An 's'/'p'/'b'-load on the same edge as a random issue: the issue completes and the command takes effect afterward.
  - A 'p' whose edge coincides with a burst decrement leaves the counter at 0.
- Reset mid-operation (`rst_n` low): all state clears immediately and asynchronously. A UART frame already in flight is not affected.

## Timing
- Reset values:
  - `tx_start`=0, `tx_byte`=0x00, `stream_active`=0, `burst_active`=0, `cmd_error`=0.
  - Parser P_IDLE, TX T_IDLE, counter 0, status_pending=0, err_sticky=0.
- Command latency:
  - `rx_valid` sampled at edge k → `stream_active`/`burst_active`/status_pending are updated after edge k.
  - The first `tx_start` is high after edge k+1 if `tx_free`=1 at k+1.
- Minimum spacing between `tx_start` pulses is 2 cycles. A pulse is never high for two consecutive cycles.
- `tx_byte` equals `rnd_byte` as sampled at the issuing edge.
- Burst of N: exactly N random `tx_start` pulses. `burst_active` falls on the edge of the Nth issue.
- `cmd_error` fires ARG_TIMEOUT cycles after the last accepted byte.

## Test plan
- Reset with `tx_free`=1 held: no `tx_start` for 1000 cycles, and all outputs are 0.
- Send 0x62, 0x00, 0x05 with `tx_free` modelled as the UART (low for 10 cycles per byte):
  - Exactly 5 pulses, each `tx_byte` matching `rnd_byte` at issue.
  - `burst_active` drops with the 5th pulse.
- Send 's', then '?' during streaming:
  - The next pulse carries 0xA1.
  - Streaming resumes.
  - After 'p', no further pulses.
- Send 0x62, 0x00, then nothing (ARG_TIMEOUT=100):
  - `cmd_error` pulses at 100 cycles.
  - A following '?' returns 0xA8, and a second '?' returns 0xA0.
- During a burst of 0x0100 send 's':
  - `burst_active`=0, and streaming continues.
  - Then 0x62, 0x00, 0x00: `stream_active`=0 and no pulses.
- Assert `rst_n` low mid-burst: outputs return to 0 asynchronously, and no pulses occur after release without a new command.

Source files
------------

// File: rtl/rng_stream_ctrl.sv
// Command-driven scheduler between the UART receiver and the free-running LFSR source.
// Decodes stream/pause/status/burst commands and paces transmit requests against tx_free.
module rng_stream_ctrl #(
  parameter int COUNT_W     = 16,
  parameter int ARG_TIMEOUT = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [7:0] rnd_byte,
  input  logic       tx_free,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       stream_active,
  output logic       burst_active,
  output logic       cmd_error
);

  localparam int TMO_W = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ARG_TIMEOUT - 1);

  localparam logic [7:0] CMD_STREAM = 8'h73;
  localparam logic [7:0] CMD_PAUSE  = 8'h70;
  localparam logic [7:0] CMD_STATUS = 8'h3F;
  localparam logic [7:0] CMD_BURST  = 8'h62;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HI   = 2'd1,
    P_LO   = 2'd2
  } pstate_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_HOLD = 1'b1
  } tstate_t;

  pstate_t              r_pstate;
  pstate_t              w_pstate_nxt;
  tstate_t              r_tstate;
  tstate_t              w_tstate_nxt;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     w_tmo_nxt;
  logic [7:0]           r_arg_hi;
  logic [7:0]           w_arg_hi_nxt;
  logic [COUNT_W-1:0]   r_cnt;
  logic [COUNT_W-1:0]   w_cnt_nxt;
  logic                 r_stream;
  logic                 w_stream_nxt;
  logic                 r_status_pend;
  logic                 w_status_pend_nxt;
  logic                 r_err_sticky;
  logic                 w_err_sticky_nxt;
  logic                 r_tx_start;
  logic                 w_tx_start_nxt;
  logic [7:0]           r_tx_byte;
  logic [7:0]           w_tx_byte_nxt;
  logic                 r_cmd_error;
  logic                 w_cmd_error_nxt;
  logic                 w_burst_active;

  function automatic logic [7:0] status_byte(input logic err, input logic in_arg,
                                             input logic burst, input logic stream);
    return {4'hA, err, in_arg, burst, stream};
  endfunction

  // Narrower counters keep only the low COUNT_W bits of the 16-bit argument.
  function automatic logic [COUNT_W-1:0] burst_len(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] arg;
    arg = {hi, lo};
    return COUNT_W'(arg);
  endfunction

  assign w_burst_active = (r_cnt != '0);

  // The scheduler is evaluated first so that a command landing on the same edge
  // overrides its effect on stream/counter/pending state.
  always_comb begin
    w_pstate_nxt      = r_pstate;
    w_tstate_nxt      = r_tstate;
    w_tmo_nxt         = r_tmo;
    w_arg_hi_nxt      = r_arg_hi;
    w_cnt_nxt         = r_cnt;
    w_stream_nxt      = r_stream;
    w_status_pend_nxt = r_status_pend;
    w_err_sticky_nxt  = r_err_sticky;
    w_tx_start_nxt    = 1'b0;
    w_tx_byte_nxt     = r_tx_byte;
    w_cmd_error_nxt   = 1'b0;

    case (r_tstate)
      T_IDLE: begin
        if (tx_free) begin
          if (r_status_pend) begin
            w_tx_start_nxt    = 1'b1;
            w_tx_byte_nxt     = status_byte(r_err_sticky, (r_pstate != P_IDLE),
                                            w_burst_active, r_stream);
            w_status_pend_nxt = 1'b0;
            w_err_sticky_nxt  = 1'b0;
            w_tstate_nxt      = T_HOLD;
          end else if (r_stream || w_burst_active) begin
            w_tx_start_nxt = 1'b1;
            w_tx_byte_nxt  = rnd_byte;
            if (w_burst_active) begin
              w_cnt_nxt = r_cnt - COUNT_W'(1);
            end
            w_tstate_nxt = T_HOLD;
          end
        end
      end
      T_HOLD: w_tstate_nxt = T_IDLE;
    endcase

    case (r_pstate)
      P_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_STREAM: begin
              w_stream_nxt = 1'b1;
              w_cnt_nxt    = '0;
            end
            CMD_PAUSE: begin
              w_stream_nxt = 1'b0;
              w_cnt_nxt    = '0;
            end
            CMD_STATUS: w_status_pend_nxt = 1'b1;
            CMD_BURST: begin
              w_pstate_nxt = P_HI;
              w_tmo_nxt    = TMO_LOAD;
            end
            default: ;
          endcase
        end
      end
      P_HI, P_LO: begin
        if (rx_valid) begin
          w_tmo_nxt = TMO_LOAD;
          if (r_pstate == P_HI) begin
            w_arg_hi_nxt = rx_byte;
            w_pstate_nxt = P_LO;
          end else begin
            w_cnt_nxt    = burst_len(r_arg_hi, rx_byte);
            w_stream_nxt = 1'b0;
            w_pstate_nxt = P_IDLE;
          end
        end else if (r_tmo == '0) begin
          w_pstate_nxt     = P_IDLE;
          w_cmd_error_nxt  = 1'b1;
          w_err_sticky_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo - TMO_W'(1);
        end
      end
      default: w_pstate_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate      <= P_IDLE;
      r_tstate      <= T_IDLE;
      r_tmo         <= '0;
      r_arg_hi      <= 8'h00;
      r_cnt         <= '0;
      r_stream      <= 1'b0;
      r_status_pend <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_cmd_error   <= 1'b0;
    end else begin
      r_pstate      <= w_pstate_nxt;
      r_tstate      <= w_tstate_nxt;
      r_tmo         <= w_tmo_nxt;
      r_arg_hi      <= w_arg_hi_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stream      <= w_stream_nxt;
      r_status_pend <= w_status_pend_nxt;
      r_err_sticky  <= w_err_sticky_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_byte     <= w_tx_byte_nxt;
      r_cmd_error   <= w_cmd_error_nxt;
    end
  end

  assign tx_start      = r_tx_start;
  assign tx_byte       = r_tx_byte;
  assign stream_active = r_stream;
  assign burst_active  = w_burst_active;
  assign cmd_error     = r_cmd_error;

  a_no_back_to_back: assert property (@(posedge clk) disable iff (!rst_n) tx_start |=> !tx_start);

endmodule

// File: tb/tb_rng_stream_ctrl.sv
// Randomized self-checking bench for rng_stream_ctrl against a transaction-level reference model.
module tb_rng_stream_ctrl;

  localparam int TMO = 100;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic [7:0] rnd_byte = 8'h00;
  logic       tx_free  = 1'b1;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       stream_active;
  logic       burst_active;
  logic       cmd_error;

  int checks = 0;
  int errors = 0;
  int free_mode = 2;  // 0 UART-like, 1 random, 2 held high, 3 held low
  int busy = 0;
  logic [7:0] edge_rnd = 8'h00;

  // Reference model state in plain integers/flags.
  bit         m_stream, m_pending, m_err, m_start, m_cmderr;
  int         m_cnt, m_argn, m_since;
  logic [7:0] m_hi, m_byte;

  always #5 clk = ~clk;

  rng_stream_ctrl #(.COUNT_W(16), .ARG_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rnd_byte(rnd_byte), .tx_free(tx_free), .tx_start(tx_start), .tx_byte(tx_byte),
    .stream_active(stream_active), .burst_active(burst_active), .cmd_error(cmd_error)
  );

  function automatic logic [11:0] dut_vec();
    return {tx_start, tx_byte, stream_active, burst_active, cmd_error};
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_start, m_byte, m_stream, (m_cnt != 0), m_cmderr};
  endfunction

  task automatic model_reset();
    m_stream = 0; m_pending = 0; m_err = 0; m_start = 0; m_cmderr = 0;
    m_cnt = 0; m_argn = 0; m_since = 0; m_hi = 8'h00; m_byte = 8'h00;
  endtask

  // One clock edge of the rules: a transmit may go out when the UART is free and the
  // previous cycle carried no request; status first, then random data. Commands win afterwards.
  task automatic model_step();
    logic [7:0] st;
    bit iss;
    st = {4'hA, m_err, (m_argn != 0), (m_cnt != 0), m_stream};
    iss = 0;
    m_cmderr = 0;
    if (tx_free && !m_start) begin
      if (m_pending) begin
        m_byte = st; m_pending = 0; m_err = 0; iss = 1;
      end else if (m_stream || m_cnt > 0) begin
        m_byte = rnd_byte; iss = 1;
        if (m_cnt > 0) m_cnt--;
      end
    end
    m_start = iss;
    if (rx_valid) begin
      m_since = 0;
      if (m_argn == 0) begin
        case (rx_byte)
          8'h73: begin m_stream = 1; m_cnt = 0; end
          8'h70: begin m_stream = 0; m_cnt = 0; end
          8'h3F: m_pending = 1;
          8'h62: m_argn = 1;
          default: ;
        endcase
      end else if (m_argn == 1) begin
        m_hi = rx_byte; m_argn = 2;
      end else begin
        m_cnt = {m_hi, rx_byte}; m_stream = 0; m_argn = 0;
      end
    end else if (m_argn != 0) begin
      m_since++;
      if (m_since == TMO) begin
        m_argn = 0; m_cmderr = 1; m_err = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_rnd = rnd_byte;
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    rx_valid = 1'b0;
    rnd_byte = 8'($urandom);
    case (free_mode)
      0: begin
        if (m_start) busy = 10; else if (busy > 0) busy--;
        tx_free = (busy == 0);
      end
      1: tx_free = 1'($urandom_range(0, 1));
      2: tx_free = 1'b1;
      default: tx_free = 1'b0;
    endcase
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
  endtask

  task automatic test_reset();
    int pulses = 0;
    free_mode = 2;
    tx_free = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (dut_vec() !== 12'h000) begin
      errors++; $display("FAIL reset_async got %h want %h", dut_vec(), 12'h000);
    end
    for (int t = 0; t < 5; t++) cycle();
    rst_n = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      cycle();
      if (tx_start) pulses++;
      checks++;
      if (dut_vec() !== 12'h000) begin
        errors++; $display("FAIL reset_idle t=%0d got %h want %h", t, dut_vec(), 12'h000);
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_pulses got %0d want 0", pulses);
    end
  endtask

  task automatic test_burst();
    int pulses = 0;
    free_mode = 0;
    for (int t = 0; t < 200; t++) begin
      if (t == 0)  drive_rx(8'h62);
      if (t == 12) drive_rx(8'h00);
      if (t == 24) drive_rx(8'h05);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL burst_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
      if (tx_start) begin
        pulses++;
        checks++;
        if (tx_byte !== edge_rnd) begin
          errors++; $display("FAIL burst_byte n=%0d got %h want %h", pulses, tx_byte, edge_rnd);
        end
        checks++;
        if (burst_active !== (pulses < 5)) begin
          errors++; $display("FAIL burst_drop n=%0d got %b want %b", pulses, burst_active, (pulses < 5));
        end
      end
    end
    checks++;
    if (pulses !== 5) begin
      errors++; $display("FAIL burst_count got %0d want 5", pulses);
    end
  endtask

  task automatic test_stream_status();
    int after_q = 0;
    int late = 0;
    bit seen = 0;
    free_mode = 0;
    for (int t = 0; t < 260; t++) begin
      if (t == 0)   drive_rx(8'h73);
      if (t == 40)  drive_rx(8'h3F);
      if (t == 150) drive_rx(8'h70);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stream_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
      if (tx_start) begin
        if (t > 40 && !seen) begin
          seen = 1;
          checks++;
          if (tx_byte !== 8'hA1) begin
            errors++; $display("FAIL stream_status_byte got %h want a1", tx_byte);
          end
        end else if (seen && t <= 150) begin
          after_q++;
        end
        if (t > 150) late++;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL stream_status_seen got %b want 1", seen);
    end
    checks++;
    if (after_q < 2) begin
      errors++; $display("FAIL stream_resume got %0d want >=2", after_q);
    end
    checks++;
    if (late !== 0) begin
      errors++; $display("FAIL pause_quiet got %0d want 0", late);
    end
  endtask

  task automatic test_absorb();
    int pulses = 0;
    logic [7:0] b = 8'h00;
    free_mode = 3;
    for (int t = 0; t < 40; t++) begin
      if (t == 0)  drive_rx(8'h3F);
      if (t == 3)  drive_rx(8'h3F);
      if (t == 10) free_mode = 2;
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL absorb_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
      if (tx_start) begin pulses++; b = tx_byte; end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL absorb_count got %0d want 1", pulses);
    end
    checks++;
    if (b !== 8'hA0) begin
      errors++; $display("FAIL absorb_byte got %h want a0", b);
    end
  endtask

  task automatic test_timeout();
    int n_err = 0;
    int err_t = -1;
    int pulses = 0;
    logic [7:0] b0 = 8'h00;
    logic [7:0] b1 = 8'h00;
    free_mode = 2;
    for (int t = 0; t < 170; t++) begin
      if (t == 0)   drive_rx(8'h62);
      if (t == 5)   drive_rx(8'h00);
      if (t == 130) drive_rx(8'h3F);
      if (t == 140) drive_rx(8'h3F);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
      if (cmd_error) begin n_err++; err_t = t; end
      if (tx_start) begin
        if (pulses == 0) b0 = tx_byte; else b1 = tx_byte;
        pulses++;
      end
    end
    checks++;
    if (n_err !== 1 || err_t !== 105) begin
      errors++; $display("FAIL timeout_pulse got n=%0d t=%0d want n=1 t=105", n_err, err_t);
    end
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL timeout_replies got %0d want 2", pulses);
    end
    checks++;
    if (b0 !== 8'hA8) begin
      errors++; $display("FAIL timeout_status1 got %h want a8", b0);
    end
    checks++;
    if (b1 !== 8'hA0) begin
      errors++; $display("FAIL timeout_status2 got %h want a0", b1);
    end
  endtask

  task automatic test_burst_override();
    int mid = 0;
    int late = 0;
    free_mode = 0;
    for (int t = 0; t < 260; t++) begin
      if (t == 0)   drive_rx(8'h62);
      if (t == 3)   drive_rx(8'h01);
      if (t == 6)   drive_rx(8'h00);
      if (t == 60)  drive_rx(8'h73);
      if (t == 150) drive_rx(8'h62);
      if (t == 153) drive_rx(8'h00);
      if (t == 156) drive_rx(8'h00);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL override_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
      if (t == 60) begin
        checks++;
        if (burst_active !== 1'b0 || stream_active !== 1'b1) begin
          errors++; $display("FAIL override_flags got b=%b s=%b want b=0 s=1", burst_active, stream_active);
        end
      end
      if (tx_start && t > 60 && t <= 150) mid++;
      if (tx_start && t > 156) late++;
    end
    checks++;
    if (mid < 3) begin
      errors++; $display("FAIL override_stream got %0d want >=3", mid);
    end
    checks++;
    if (late !== 0 || stream_active !== 1'b0) begin
      errors++; $display("FAIL zero_burst got pulses=%0d s=%b want 0 0", late, stream_active);
    end
  endtask

  task automatic test_random();
    free_mode = 1;
    for (int t = 0; t < 900; t++) begin
      if ((t % 300) < 180 && $urandom_range(0, 7) == 0) begin
        if (m_argn == 1) drive_rx(8'($urandom_range(0, 1)));
        else begin
          case ($urandom_range(0, 5))
            0: drive_rx(8'h73);
            1: drive_rx(8'h70);
            2: drive_rx(8'h3F);
            3: drive_rx(8'h62);
            4: drive_rx(8'h72);
            default: drive_rx(8'($urandom));
          endcase
        end
      end
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int pulses = 0;
    free_mode = 2;
    for (int t = 0; t < 30; t++) begin
      if (t == 0) drive_rx(8'h70);
      if (t == 2) drive_rx(8'h62);
      if (t == 3) drive_rx(8'h00);
      if (t == 4) drive_rx(8'h40);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_model t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (burst_active !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got %b want 1", burst_active);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 12'h000) begin
      errors++; $display("FAIL midrst_async got %h want %h", dut_vec(), 12'h000);
    end
    for (int t = 0; t < 3; t++) begin
      cycle();
      checks++;
      if (dut_vec() !== 12'h000) begin
        errors++; $display("FAIL midrst_hold got %h want %h", dut_vec(), 12'h000);
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      cycle();
      if (tx_start) pulses++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_after t=%0d got %h want %h", t, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midrst_quiet got %0d want 0", pulses);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_burst();
    test_stream_status();
    test_absorb();
    test_timeout();
    test_burst_override();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
